// File: rtl/pow2_multiplier.sv
// Sequential saturating power-of-two multiplier: out = min(in << n, all-ones),
// one left shift per clock, valid/ready handshakes on both sides.
module pow2_multiplier #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [NW-1:0]    n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             sat
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_d;
  logic [NW-1:0]    r_cnt;
  logic [NW-1:0]    w_cnt_d;
  logic             r_sat;
  logic             w_sat_d;
  logic             w_accept;
  logic             w_msb;

  assign w_accept = in_valid && in_ready;
  assign w_msb    = r_acc[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = ((n == '0) || (in == '0)) ? StDone : StShift;
        end
      end
      StShift: begin
        // A set MSB means the next shift would overflow, so clamp now.
        if (w_msb || (r_cnt == NW'(1))) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (r_state == StIdle);
    out_valid = (r_state == StDone);
    out       = r_acc;
    sat       = r_sat;
  end

  always_comb begin
    w_acc_d = r_acc;
    w_cnt_d = r_cnt;
    w_sat_d = r_sat;
    if (r_state == StIdle) begin
      if (w_accept) begin
        w_acc_d = in;
        w_cnt_d = n;
        w_sat_d = 1'b0;
      end
    end else if (r_state == StShift) begin
      if (w_msb) begin
        w_acc_d = '1;
        w_sat_d = 1'b1;
      end else begin
        w_acc_d = r_acc << 1;
        w_cnt_d = r_cnt - NW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_acc <= w_acc_d;
      r_cnt <= w_cnt_d;
      r_sat <= w_sat_d;
    end
  end

endmodule

// File: tb/tb_pow2_multiplier.sv
// Directed bench for pow2_multiplier: vector table plus backpressure and
// mid-operation reset sequences.
module tb_pow2_multiplier;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [NW-1:0]    n;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             sat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] in;
    logic [NW-1:0]    n;
    logic [WIDTH-1:0] exp_out;
    logic             exp_sat;
    int               exp_k;
  } vec_t;

  vec_t vecs[12];

  pow2_multiplier #(
    .WIDTH(WIDTH),
    .NW   (NW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (din),
    .n        (n),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (dout),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Count edges after the accepting edge until out_valid is seen (sampled #1 after edges).
  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  // Drive one operand from IDLE; returns after the accepting edge (+#1).
  task automatic accept(input logic [WIDTH-1:0] a, input logic [NW-1:0] s, input string name);
    @(negedge clk);
    din      = a;
    n        = s;
    in_valid = 1'b1;
    chk({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int k;
    logic stale;

    vecs[0]  = '{8'd5,  4'd3,  8'd40, 1'b0, 3};
    vecs[1]  = '{8'h90, 4'd2,  8'hFF, 1'b1, 1};
    vecs[2]  = '{8'h40, 4'd1,  8'h80, 1'b0, 1};
    vecs[3]  = '{8'h40, 4'd2,  8'hFF, 1'b1, 2};
    vecs[4]  = '{8'hAB, 4'd0,  8'hAB, 1'b0, 0};
    vecs[5]  = '{8'h00, 4'd15, 8'h00, 1'b0, 0};
    vecs[6]  = '{8'h01, 4'd15, 8'hFF, 1'b1, 8};
    vecs[7]  = '{8'h01, 4'd7,  8'h80, 1'b0, 7};
    vecs[8]  = '{8'h03, 4'd6,  8'hC0, 1'b0, 6};
    vecs[9]  = '{8'hFF, 4'd1,  8'hFF, 1'b1, 1};
    vecs[10] = '{8'h7F, 4'd1,  8'hFE, 1'b0, 1};
    vecs[11] = '{8'h81, 4'd0,  8'h81, 1'b0, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din       = '0;
    n         = '0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("in_ready low in reset", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset out", 32'(dout), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sat", 32'(sat), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // Vector table, out_ready held high
    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      accept(vecs[i].in, vecs[i].n, tag);
      wait_valid(k);
      chk({tag, " latency"}, 32'(k), 32'(vecs[i].exp_k));
      chk({tag, " out"}, 32'(dout), 32'(vecs[i].exp_out));
      chk({tag, " sat"}, 32'(sat), 32'(vecs[i].exp_sat));
      chk({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, " out_valid after handoff"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready after handoff"}, 32'(in_ready), 32'd1);
    end

    // Backpressure with a pending operand
    out_ready = 1'b0;
    accept(8'd5, 4'd3, "bp");
    wait_valid(k);
    chk("bp latency", 32'(k), 32'd3);
    @(negedge clk);
    din      = 8'h21;
    n        = 4'd2;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp hold out c%0d", c), 32'(dout), 32'd40);
      chk($sformatf("bp hold sat c%0d", c), 32'(sat), 32'd0);
      chk($sformatf("bp hold valid c%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold in_ready c%0d", c), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp handoff out_valid", 32'(out_valid), 32'd0);
    chk("bp handoff in_ready", 32'(in_ready), 32'd1);
    chk("bp idle keeps out", 32'(dout), 32'd40);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp pending accepted", 32'(in_ready), 32'd0);
    wait_valid(k);
    chk("bp pending latency", 32'(k), 32'd2);
    chk("bp pending out", 32'(dout), 32'h84);
    chk("bp pending sat", 32'(sat), 32'd0);
    @(posedge clk);
    #1;

    // Reset during SHIFT
    accept(8'd3, 4'd6, "rst");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst out", 32'(dout), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst sat", 32'(sat), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    stale = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale = 1'b1;
    end
    chk("rst no stale result", 32'(stale), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
